// File: rtl/phase_sched_pkg.sv
// Shared types and constants for the intersection phase scheduler and
// anything else that needs to speak in terms of lanes and phase states.
package phase_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2,
        ALL_RED = 2'd3
    } state_t;

    localparam logic [1:0] LANE_NS1 = 2'd0;
    localparam logic [1:0] LANE_NS2 = 2'd1;
    localparam logic [1:0] LANE_EW1 = 2'd2;
    localparam logic [1:0] LANE_EW2 = 2'd3;

    localparam int NUM_LANES = 4;

    // One-hot lane mask, bit order matches the req/cong/green vectors
    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [1:0] lane);
        lane_onehot = 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/rr_lane_picker.sv
// Round-robin lane chooser with emergency override. Purely combinational so
// it can be shared with other schedulers that keep their own pointer.
module rr_lane_picker
    import phase_sched_pkg::*;
(
    input  logic [NUM_LANES-1:0] cand,
    input  logic [1:0]           ptr,
    input  logic                 emg_req,
    input  logic [1:0]           emg_lane,
    output logic                 sel_valid,
    output logic [1:0]           sel_lane
);

    // order_idx[k] is the lane visited at search position k: ptr+1 first,
    // ptr itself last, so the lane just served only wins when it is alone.
    logic [1:0]           order_idx [NUM_LANES];
    logic [NUM_LANES-1:0] order_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_order
            assign order_idx[gi] = ptr + 2'(gi + 1);
            assign order_hit[gi] = cand[order_idx[gi]];
        end
    endgenerate

    // Emergency lane wins outright; otherwise the earliest hit in search order
    always_comb begin
        sel_valid = 1'b0;
        sel_lane  = ptr;
        if (emg_req) begin
            sel_valid = 1'b1;
            sel_lane  = emg_lane;
        end else begin
            // Walk from the back so the lowest search position is written last
            for (int k = NUM_LANES - 1; k >= 0; k--) begin
                if (order_hit[k]) begin
                    sel_valid = 1'b1;
                    sel_lane  = order_idx[k];
                end
            end
        end
    end

endmodule

// File: rtl/phase_scheduler.sv
// Four-approach right-of-way sequencer: round-robin grants with a minimum
// green, congestion extensions up to a cap, yellow and all-red clearance,
// and an emergency pre-empt. All light outputs are registered.
module phase_scheduler
    import phase_sched_pkg::*;
#(
    parameter int MIN_GREEN  = 10,
    parameter int EXT_STEP   = 5,
    parameter int MAX_GREEN  = 30,
    parameter int YELLOW_CYC = 3,
    parameter int ALLRED_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] req,
    input  logic [NUM_LANES-1:0] cong,
    input  logic                 emg_req,
    input  logic [1:0]           emg_lane,
    output logic [NUM_LANES-1:0] green,
    output logic [NUM_LANES-1:0] yellow,
    output logic                 all_red,
    output logic [1:0]           active_lane,
    output logic [CNT_W-1:0]     phase_cnt,
    output logic                 served
);

    localparam logic [CNT_W-1:0] MIN_G   = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] EXT_G   = CNT_W'(EXT_STEP);
    localparam logic [CNT_W:0]   MAX_G_W = (CNT_W+1)'(MAX_GREEN);
    localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t               state_reg,   state_next;
    logic [CNT_W-1:0]     cnt_reg,     cnt_next;
    logic [CNT_W-1:0]     limit_reg,   limit_next;
    logic [1:0]           lane_reg,    lane_next;
    logic [1:0]           ptr_reg,     ptr_next;
    logic [NUM_LANES-1:0] pending_reg, pending_next;

    logic [NUM_LANES-1:0] green_next;
    logic [NUM_LANES-1:0] yellow_next;
    logic                 all_red_next;
    logic                 served_next;

    logic [NUM_LANES-1:0] req_eff;
    logic [NUM_LANES-1:0] cand;
    logic [NUM_LANES-1:0] grant_mask;
    logic                 sel_valid;
    logic [1:0]           sel_lane;
    logic                 grant;
    logic [CNT_W-1:0]     limit_m1;
    logic [CNT_W:0]       ext_sum;
    logic                 ext_ok;

    // A lane that is already green cannot re-request itself; the registered
    // green vector is exactly the one-hot of the lane holding GREEN.
    assign req_eff  = req & ~green;
    assign cand     = pending_reg | req_eff;

    assign limit_m1 = limit_reg - ONE;
    // One extra bit so limit+EXT_STEP cannot wrap before it is compared
    assign ext_sum  = {1'b0, limit_reg} + {1'b0, EXT_G};
    assign ext_ok   = (ext_sum <= MAX_G_W);

    assign active_lane = lane_reg;
    assign phase_cnt   = cnt_reg;

    rr_lane_picker u_picker (
        .cand      (cand),
        .ptr       (ptr_reg),
        .emg_req   (emg_req),
        .emg_lane  (emg_lane),
        .sel_valid (sel_valid),
        .sel_lane  (sel_lane)
    );

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            limit_reg   <= MIN_G;
            lane_reg    <= LANE_EW2;
            ptr_reg     <= LANE_EW2;
            pending_reg <= '0;
            green       <= '0;
            yellow      <= '0;
            all_red     <= 1'b1;
            served      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            limit_reg   <= limit_next;
            lane_reg    <= lane_next;
            ptr_reg     <= ptr_next;
            pending_reg <= pending_next;
            green       <= green_next;
            yellow      <= yellow_next;
            all_red     <= all_red_next;
            served      <= served_next;
        end
    end

    // Next-state, phase counter, green limit and grant bookkeeping
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        limit_next = limit_reg;
        lane_next  = lane_reg;
        ptr_next   = ptr_reg;
        grant      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (sel_valid) begin
                    grant = 1'b1;
                end
            end

            GREEN: begin
                if (emg_req && (emg_lane != lane_reg)) begin
                    // Pre-empted by another lane: clear immediately
                    state_next = YELLOW;
                end else if (cnt_reg == limit_m1) begin
                    if (emg_req) begin
                        // Emergency is for this lane: hold the exit, freeze count
                        cnt_next = cnt_reg;
                    end else if (cong[lane_reg] && ext_ok) begin
                        limit_next = limit_reg + EXT_G;
                        cnt_next   = cnt_reg + ONE;
                    end else begin
                        state_next = YELLOW;
                    end
                end else begin
                    cnt_next = cnt_reg + ONE;
                end
            end

            YELLOW: begin
                if (cnt_reg == Y_LAST) begin
                    state_next = ALL_RED;
                end else begin
                    cnt_next = cnt_reg + ONE;
                end
            end

            ALL_RED: begin
                if (cnt_reg == AR_LAST) begin
                    if (sel_valid) begin
                        grant = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + ONE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (grant) begin
            state_next = GREEN;
            limit_next = MIN_G;
            lane_next  = sel_lane;
            ptr_next   = sel_lane;
        end

        if (state_next != state_reg) begin
            cnt_next = '0;
        end

        // Requests keep accumulating (even the cycle another lane is granted);
        // only the lane being granted this cycle is cleared.
        grant_mask   = grant ? lane_onehot(sel_lane) : '0;
        pending_next = (pending_reg | req_eff) & ~grant_mask;
    end

    // Light outputs decoded from the upcoming state so they register in step
    always_comb begin
        green_next   = '0;
        yellow_next  = '0;
        all_red_next = 1'b0;
        served_next  = (state_reg == GREEN) && (state_next == YELLOW);
        case (state_next)
            GREEN:   green_next   = lane_onehot(lane_next);
            YELLOW:  yellow_next  = lane_onehot(lane_next);
            default: all_red_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_phase_scheduler.sv
// Directed bench for phase_scheduler: single grant timing, rotation,
// congestion cap (default and reduced MAX_GREEN), emergency pre-empt and
// asynchronous reset in mid-phase.
module tb_phase_scheduler;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [3:0]       cong;
    logic             emg_req;
    logic [1:0]       emg_lane;

    logic [3:0]       green_a, yellow_a, green_b, yellow_b;
    logic             all_red_a, all_red_b;
    logic [1:0]       lane_a, lane_b;
    logic [CNT_W-1:0] cnt_a, cnt_b;
    logic             served_a, served_b;

    int n_checks = 0;
    int n_pass   = 0;
    int served_cnt = 0;
    logic [1:0] served_lane = 2'd0;

    always #5 clk = ~clk;

    phase_scheduler dut_a (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .cong        (cong),
        .emg_req     (emg_req),
        .emg_lane    (emg_lane),
        .green       (green_a),
        .yellow      (yellow_a),
        .all_red     (all_red_a),
        .active_lane (lane_a),
        .phase_cnt   (cnt_a),
        .served      (served_a)
    );

    phase_scheduler #(.MAX_GREEN(22)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .cong        (cong),
        .emg_req     (emg_req),
        .emg_lane    (emg_lane),
        .green       (green_b),
        .yellow      (yellow_b),
        .all_red     (all_red_b),
        .active_lane (lane_b),
        .phase_cnt   (cnt_b),
        .served      (served_b)
    );

    // served pulse monitor for the default-parameter instance
    always @(negedge clk) begin
        if (served_a) begin
            served_cnt++;
            served_lane = lane_a;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic nstep();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; cong = '0; emg_req = 1'b0; emg_lane = 2'd0;
        nstep();
        nstep();
        rst = 1'b1;
        nstep();
    endtask

    function automatic logic [3:0] sig(input int which);
        case (which)
            0:       sig = green_a;
            1:       sig = yellow_a;
            2:       sig = green_b;
            default: sig = yellow_b;
        endcase
    endfunction

    // Count consecutive cycles for which the chosen vector equals mask
    task automatic measure(input int which, input logic [3:0] mask, output int n);
        n = 0;
        while (sig(which) == mask && n < 100) begin
            n++;
            nstep();
        end
        if (n >= 100) check("measure_timeout", n, 0);
    endtask

    // Count cycles until some lane goes green
    task automatic wait_green(output int gap);
        gap = 0;
        while (green_a == 4'b0000 && gap < 100) begin
            gap++;
            nstep();
        end
        if (gap >= 100) check("wait_green_timeout", gap, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, gap, base, k, na, nb, ya, yb;
        int exp_lanes [5];
        exp_lanes = '{0, 1, 2, 3, 0};

        // ---------------- reset state ----------------
        rst = 1'b0; req = '0; cong = '0; emg_req = 1'b0; emg_lane = 2'd0;
        nstep();
        nstep();
        check("rst_green", green_a, 0);
        check("rst_yellow", yellow_a, 0);
        check("rst_all_red", all_red_a, 1);
        check("rst_active_lane", lane_a, 3);
        check("rst_phase_cnt", cnt_a, 0);
        check("rst_served", served_a, 0);
        rst = 1'b1;
        nstep();

        // ---------------- single lane ----------------
        base = served_cnt;
        req = 4'b0100;
        nstep();
        req = 4'b0000;
        check("single_green", green_a, 4'b0100);
        check("single_lane", lane_a, 2);
        check("single_cnt0", cnt_a, 0);
        measure(0, 4'b0100, n);
        check("single_green_len", n, 10);
        check("single_yellow", yellow_a, 4'b0100);
        check("single_served", served_a, 1);
        measure(1, 4'b0100, n);
        check("single_yellow_len", n, 3);
        check("single_allred0", all_red_a, 1);
        check("single_allred0_cnt", cnt_a, 0);
        nstep();
        check("single_allred1_cnt", cnt_a, 1);
        nstep();
        check("single_idle_cnt", cnt_a, 0);
        check("single_idle_allred", all_red_a, 1);
        nstep(); nstep(); nstep();
        check("single_idle_stays", green_a | yellow_a, 0);
        check("single_served_count", served_cnt - base, 1);
        check("single_served_lane", served_lane, 2);
        $display("txn single: lane 2 served once");

        // ---------------- rotation ----------------
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_green(gap);
            if (g > 0) check("rot_gap", gap, 5);
            check("rot_lane", lane_a, exp_lanes[g]);
            check("rot_onehot", green_a, 1 << exp_lanes[g]);
            measure(0, green_a, n);
            check("rot_len", n, 10);
            $display("txn rotation: grant %0d lane %0d green %0d cycles gap %0d", g, exp_lanes[g], n, gap);
        end
        req = 4'b0000;

        // ---------------- congestion cap / overshoot ----------------
        do_reset();
        req = 4'b0010;
        cong = 4'b0010;
        nstep();
        req = 4'b0000;
        check("cong_start_a", green_a, 4'b0010);
        check("cong_start_b", green_b, 4'b0010);
        na = 0; nb = 0; ya = 0; yb = 0;
        for (int c = 0; c < 50; c++) begin
            if (green_a == 4'b0010) na++;
            if (green_b == 4'b0010) nb++;
            if (yellow_a == 4'b0010) ya++;
            if (yellow_b == 4'b0010) yb++;
            nstep();
        end
        check("cong_cap_len_a", na, 30);
        check("cong_overshoot_len_b", nb, 20);
        check("cong_yellow_a", ya, 3);
        check("cong_yellow_b", yb, 3);
        $display("txn congestion: green %0d cycles (cap 30), %0d cycles (cap 22)", na, nb);
        cong = 4'b0000;

        // ---------------- emergency pre-empt ----------------
        do_reset();
        req = 4'b0011;
        nstep();
        req = 4'b0000;
        check("emg_first_green", green_a, 4'b0001);
        k = 0;
        while (cnt_a != 4 && k < 20) begin
            k++;
            nstep();
        end
        check("emg_cnt_at_4", cnt_a, 4);
        emg_req = 1'b1;
        emg_lane = 2'd3;
        nstep();
        check("emg_yellow_next", yellow_a, 4'b0001);
        check("emg_green_off", green_a, 0);
        check("emg_served", served_a, 1);
        measure(1, 4'b0001, n);
        check("emg_yellow_len", n, 3);
        n = 0;
        while (all_red_a && n < 20) begin
            n++;
            nstep();
        end
        check("emg_allred_len", n, 2);
        check("emg_green_lane3", green_a, 4'b1000);
        check("emg_active_lane", lane_a, 3);
        emg_req = 1'b0;
        measure(0, 4'b1000, n);
        check("emg_lane3_len", n, 10);
        wait_green(gap);
        check("emg_after_gap", gap, 5);
        check("emg_pending_lane1", green_a, 4'b0010);
        $display("txn emergency: lane 0 pre-empted, lane 3 granted, then pending lane 1");

        // ---------------- async reset mid-yellow ----------------
        do_reset();
        req = 4'b0001;
        nstep();
        req = 4'b0000;
        measure(0, 4'b0001, n);
        nstep();
        check("arst_mid_yellow", yellow_a, 4'b0001);
        #2;
        rst = 1'b0;
        #1;
        check("arst_green", green_a, 0);
        check("arst_yellow", yellow_a, 0);
        check("arst_all_red", all_red_a, 1);
        check("arst_lane", lane_a, 3);
        check("arst_cnt", cnt_a, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        req = 4'b0011;
        nstep();
        req = 4'b0000;
        check("arst_first_green", green_a, 4'b0001);
        check("arst_first_lane", lane_a, 0);
        $display("txn async reset: outputs cleared mid-yellow, lane 0 served first after release");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
